// File: rtl/sram_pixel_writer.sv
// Buffers pixel writes into a small FIFO and drains them to an asynchronous SRAM,
// interleaving single-word reads. Optional frame counter: SRAM_PIXEL_WRITER_FRAME_CNT_EN.
module sram_pixel_writer #(
  parameter int HEIGHT     = 640,
  parameter int WIDTH      = 640,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic        i_wr_valid,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ready,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic        o_rd_ack,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  output logic [19:0] o_SRAM_ADDR,
  inout  wire  [15:0] io_SRAM_DQ,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N,
  output logic        o_frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_SETUP = 2'd1,
    S_WR_PULSE = 2'd2,
    S_RD       = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [19:0]       fifo_addr_r [FIFO_DEPTH];
  logic [15:0]       fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              rd_ack_s;
  logic [19:0]       sram_addr_r;
  logic [15:0]       dq_out_r;
  logic              dq_oe_r;
  logic              we_n_r;
  logic              oe_n_r;
  logic [15:0]       rd_data_r;
  logic              rd_valid_r;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = i_wr_valid & ~full_s;
  assign pop_s   = (state_r == S_WR_PULSE);

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge avm_clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= i_wr_addr;
      fifo_data_r[wr_ptr_r] <= i_wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // State register.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) state_r <= S_IDLE;
    else            state_r <= state_nxt_s;
  end

  // Next state; a full FIFO pre-empts a pending read so the writer never deadlocks.
  always_comb begin
    state_nxt_s = state_r;
    rd_ack_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (full_s) begin
          state_nxt_s = S_WR_SETUP;
        end else if (i_rd_req) begin
          state_nxt_s = S_RD;
          rd_ack_s    = 1'b1;
        end else if (!empty_s) begin
          state_nxt_s = S_WR_SETUP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WR_SETUP: state_nxt_s = S_WR_PULSE;
      S_WR_PULSE: state_nxt_s = S_IDLE;
      S_RD:       state_nxt_s = S_IDLE;
      default:    state_nxt_s = S_IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so strobes are glitch-free.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      sram_addr_r <= 20'd0;
      dq_out_r    <= 16'd0;
      dq_oe_r     <= 1'b0;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      rd_data_r   <= 16'd0;
      rd_valid_r  <= 1'b0;
    end else begin
      we_n_r     <= (state_nxt_s != S_WR_PULSE);
      oe_n_r     <= (state_nxt_s != S_RD);
      dq_oe_r    <= (state_nxt_s == S_WR_SETUP) || (state_nxt_s == S_WR_PULSE);
      rd_valid_r <= (state_r == S_RD);
      if (state_r == S_RD) rd_data_r <= io_SRAM_DQ;
      if (state_nxt_s == S_WR_SETUP) begin
        sram_addr_r <= fifo_addr_r[rd_ptr_r];
        dq_out_r    <= fifo_data_r[rd_ptr_r];
      end else if (rd_ack_s) begin
        sram_addr_r <= i_rd_addr;
      end
    end
  end

  assign io_SRAM_DQ  = dq_oe_r ? dq_out_r : {16{1'bz}};
  assign o_SRAM_ADDR = sram_addr_r;
  assign o_SRAM_WE_N = we_n_r;
  assign o_SRAM_OE_N = oe_n_r;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_wr_ready  = ~full_s;
  assign o_rd_ack    = rd_ack_s;
  assign o_rd_data   = rd_data_r;
  assign o_rd_valid  = rd_valid_r;

`ifdef SRAM_PIXEL_WRITER_FRAME_CNT_EN
  localparam int FRAME_PIX = HEIGHT * WIDTH;
  localparam int FCNT_W    = $clog2(FRAME_PIX + 1);

  logic [FCNT_W-1:0] pix_cnt_r;
  logic              frame_done_r;

  // Counts completed write pulses; the done flag is sticky until reset.
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      pix_cnt_r    <= {FCNT_W{1'b0}};
      frame_done_r <= 1'b0;
    end else if (state_r == S_WR_PULSE) begin
      if (pix_cnt_r == FCNT_W'(FRAME_PIX - 1)) begin
        pix_cnt_r    <= {FCNT_W{1'b0}};
        frame_done_r <= 1'b1;
      end else begin
        pix_cnt_r <= pix_cnt_r + FCNT_W'(1);
      end
    end
  end

  assign o_frame_done = frame_done_r;
`else
  assign o_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_sram_pixel_writer.sv
// Scoreboard bench for sram_pixel_writer: directed cases plus randomized traffic
// against a behavioural SRAM and FIFO-occupancy model.
module tb_sram_pixel_writer;

  localparam int DEPTH = 4;

  logic        avm_clk = 1'b0;
  logic        avm_rst_n;
  logic        i_wr_valid;
  logic [19:0] i_wr_addr;
  logic [15:0] i_wr_data;
  logic        o_wr_ready;
  logic        i_rd_req;
  logic [19:0] i_rd_addr;
  logic        o_rd_ack;
  logic [15:0] o_rd_data;
  logic        o_rd_valid;
  logic [19:0] o_SRAM_ADDR;
  wire  [15:0] sram_dq;
  logic        o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N;
  logic        o_frame_done;

  sram_pixel_writer #(.HEIGHT(4), .WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
    .avm_clk(avm_clk), .avm_rst_n(avm_rst_n),
    .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ready(o_wr_ready),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_SRAM_ADDR(o_SRAM_ADDR), .io_SRAM_DQ(sram_dq),
    .o_SRAM_WE_N(o_SRAM_WE_N), .o_SRAM_CE_N(o_SRAM_CE_N), .o_SRAM_OE_N(o_SRAM_OE_N),
    .o_SRAM_LB_N(o_SRAM_LB_N), .o_SRAM_UB_N(o_SRAM_UB_N),
    .o_frame_done(o_frame_done)
  );

  always #5 avm_clk = ~avm_clk;

  // Behavioural SRAM: 256 words, aliasing on the low address byte.
  logic [15:0] sram_mem [256];
  logic [15:0] sram_rd_word;
  assign sram_rd_word = sram_mem[o_SRAM_ADDR[7:0]];
  assign sram_dq = (!o_SRAM_OE_N && o_SRAM_WE_N) ? sram_rd_word : 16'hzzzz;
  always @(posedge avm_clk) if (!o_SRAM_WE_N) sram_mem[o_SRAM_ADDR[7:0]] <= sram_dq;

  typedef struct packed { logic [19:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [15:0] d; logic [31:0] c; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];

  int n_vec = 0, n_fail = 0;
  int cyc = 0, occ = 0, n_pulse = 0, n_ack = 0, pulses_total = 0;
  int last_pulse_cyc = 0, last_acc_cyc = 0;
  logic prev_pulse = 1'b0, prev_we_n = 1'b1;
  logic [19:0] prev_addr = 20'd0;
  logic [15:0] prev_dq = 16'd0;
  logic last_wr_acc = 1'b0, last_rd_ack = 1'b0;
  logic mon_acc, mon_pulse, exp_fd;
  wr_t mw;
  rd_t mr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge avm_clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, pops expectations whenever the DUT presents output.
  always @(negedge avm_clk) begin
    if (avm_rst_n) begin
      mon_acc   = i_wr_valid && o_wr_ready;
      mon_pulse = !o_SRAM_WE_N;
`ifdef SRAM_PIXEL_WRITER_FRAME_CNT_EN
      exp_fd = (pulses_total >= 16);
`else
      exp_fd = 1'b0;
`endif
      chk("wr_ready", {31'd0, o_wr_ready}, {31'd0, occ < DEPTH});
      chk("frame_done", {31'd0, o_frame_done}, {31'd0, exp_fd});
      chk("ce_lb_ub", {29'd0, o_SRAM_CE_N, o_SRAM_LB_N, o_SRAM_UB_N}, 32'd0);
      if (prev_pulse) chk("we_one_cycle", {31'd0, o_SRAM_WE_N}, 32'd1);
      if (mon_pulse) begin
        chk("oe_during_write", {31'd0, o_SRAM_OE_N}, 32'd1);
        if (wr_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL wr_unexpected: pulse at addr %0h with nothing pending", o_SRAM_ADDR);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", {12'd0, o_SRAM_ADDR}, {12'd0, mw.a});
          chk("wr_data", {16'd0, sram_dq}, {16'd0, mw.d});
          chk("setup_addr", {12'd0, prev_addr}, {12'd0, mw.a});
          chk("setup_data", {16'd0, prev_dq}, {16'd0, mw.d});
          chk("setup_we_n", {31'd0, prev_we_n}, 32'd1);
        end
        n_pulse++;
        pulses_total++;
        last_pulse_cyc = cyc;
      end
      if (o_rd_ack) begin
        chk("ack_not_full", {31'd0, occ < DEPTH}, 32'd1);
        chk("ack_with_req", {31'd0, i_rd_req}, 32'd1);
        mr.d = sram_mem[i_rd_addr[7:0]];
        mr.c = cyc + 2;
        rd_q.push_back(mr);
        n_ack++;
      end
      if (o_rd_valid) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL rd_unexpected: valid with data %0h and no read pending", o_rd_data);
        end else begin
          mr = rd_q.pop_front();
          chk("rd_data", {16'd0, o_rd_data}, {16'd0, mr.d});
          chk("rd_latency", cyc, mr.c);
        end
      end
      if (mon_acc) begin
        wr_q.push_back({i_wr_addr, i_wr_data});
        last_acc_cyc = cyc;
      end
      occ = occ + int'(mon_acc) - int'(mon_pulse);
      prev_pulse  = mon_pulse;
      prev_we_n   = o_SRAM_WE_N;
      prev_addr   = o_SRAM_ADDR;
      prev_dq     = sram_dq;
      last_wr_acc = mon_acc;
      last_rd_ack = o_rd_ack;
    end
  end

  task automatic tick();
    @(posedge avm_clk); #1;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d);
    int n = 0;
    logic acc = 1'b0;
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d;
    while (!acc && n < 200) begin
      @(negedge avm_clk); acc = o_wr_ready;
      tick(); n++;
    end
    i_wr_valid = 1'b0;
    if (!acc) begin n_vec++; n_fail++; $display("FAIL wr_timeout: addr %0h not accepted", a); end
  endtask

  task automatic do_read(input logic [19:0] a);
    int n = 0;
    logic ack = 1'b0;
    i_rd_req = 1'b1; i_rd_addr = a;
    while (!ack && n < 200) begin
      @(negedge avm_clk); ack = o_rd_ack;
      tick(); n++;
    end
    i_rd_req = 1'b0;
    if (!ack) begin n_vec++; n_fail++; $display("FAIL rd_timeout: addr %0h not acked", a); end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wr_q.size() != 0 || rd_q.size() != 0) && n < 1000) begin tick(); n++; end
    repeat (3) tick();
    if (n >= 1000) begin n_vec++; n_fail++; $display("FAIL drain_timeout: wr %0d rd %0d left", wr_q.size(), rd_q.size()); end
  endtask

  task automatic reset_model();
    wr_q.delete(); rd_q.delete();
    occ = 0; pulses_total = 0; prev_pulse = 1'b0; prev_we_n = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we_n"}, {31'd0, o_SRAM_WE_N}, 32'd1);
    chk({tag, "_oe_n"}, {31'd0, o_SRAM_OE_N}, 32'd1);
    chk({tag, "_ready"}, {31'd0, o_wr_ready}, 32'd1);
    chk({tag, "_ack"}, {31'd0, o_rd_ack}, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_rd_valid}, 32'd0);
    chk({tag, "_rd_data"}, {16'd0, o_rd_data}, 32'd0);
    chk({tag, "_addr"}, {12'd0, o_SRAM_ADDR}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, o_frame_done}, 32'd0);
  endtask

  initial begin
    int a0, p0, n, p_before;
    logic got;
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'(i * 16'h0101);
    avm_rst_n = 1'b0; i_wr_valid = 1'b0; i_wr_addr = 20'd0; i_wr_data = 16'd0;
    i_rd_req = 1'b0; i_rd_addr = 20'd0;
    repeat (3) @(posedge avm_clk);
    @(negedge avm_clk);
    chk_reset_outputs("reset");
    tick(); avm_rst_n = 1'b1; tick();

    // Single write: pulse three cycles after acceptance, exactly one pulse.
    p_before = n_pulse;
    do_write(20'h00010, 16'hBEEF);
    wait_idle();
    chk("single_wr_pulses", n_pulse - p_before, 32'd1);
    chk("single_wr_latency", last_pulse_cyc - last_acc_cyc, 32'd3);

    // Read back the written word.
    do_read(20'h00010);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge avm_clk); #1;
      if (o_rd_valid) begin got = 1'b1; chk("readback_beef", {16'd0, o_rd_data}, 32'h0000BEEF); end
    end
    if (!got) begin n_vec++; n_fail++; $display("FAIL readback_timeout: no rd_valid"); end
    tick();
    wait_idle();

    // Burst of five back-to-back writes fills the buffer.
    i_wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_wr_addr = 20'h00020 + 20'(i); i_wr_data = 16'($urandom);
      n = 0;
      do begin @(negedge avm_clk); got = o_wr_ready; tick(); n++; end while (!got && n < 50);
    end
    i_wr_valid = 1'b0;
    wait_idle();

    // Full buffer with a read held: one write first, then the read, then writes again.
    i_rd_req = 1'b1; i_rd_addr = 20'h00021;
    for (int i = 0; i < 4; i++) do_write(20'h00040 + 20'(i), 16'($urandom));
    i_rd_req = 1'b1;
    chk("prio_fifo_full", occ, DEPTH);
    a0 = n_ack; p0 = n_pulse; n = 0;
    while (n_ack == a0 && n_pulse == p0 && n < 50) begin @(negedge avm_clk); #1; n++; end
    chk("prio_write_first", n_pulse - p0, 32'd1);
    chk("prio_no_ack_while_full", n_ack - a0, 32'd0);
    a0 = n_ack; p0 = n_pulse; n = 0;
    while (n_ack == a0 && n_pulse == p0 && n < 50) begin @(negedge avm_clk); #1; n++; end
    chk("prio_read_next", n_ack - a0, 32'd1);
    chk("prio_no_write_before_read", n_pulse - p0, 32'd0);
    tick(); i_rd_req = 1'b0;
    wait_idle();

    // Randomized traffic: requests held until accepted.
    for (int c = 0; c < 600; c++) begin
      tick();
      if (i_wr_valid && last_wr_acc) i_wr_valid = 1'b0;
      if (i_rd_req && last_rd_ack) i_rd_req = 1'b0;
      if (!i_wr_valid && ($urandom % 2 == 0)) begin
        i_wr_valid = 1'b1; i_wr_addr = 20'($urandom_range(0, 255)); i_wr_data = 16'($urandom);
      end
      if (!i_rd_req && ($urandom % 4 == 0)) begin
        i_rd_req = 1'b1; i_rd_addr = 20'($urandom_range(0, 255));
      end
    end
    @(negedge avm_clk);
    tick();
    i_wr_valid = 1'b0; i_rd_req = 1'b0;
    wait_idle();

    // Reset during a write pulse discards the interrupted and buffered words.
    i_wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_wr_addr = 20'h00080 + 20'(i); i_wr_data = 16'($urandom);
      tick();
    end
    i_wr_valid = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 50) begin @(negedge avm_clk); got = !o_SRAM_WE_N; n++; end
    chk("rst_saw_pulse", {31'd0, got}, 32'd1);
    #2 avm_rst_n = 1'b0;
    #1 chk_reset_outputs("midwrite_rst");
    reset_model();
    tick(); tick(); avm_rst_n = 1'b1;
    p_before = n_pulse;
    repeat (12) tick();
    chk("rst_no_pulses", n_pulse - p_before, 32'd0);
    chk("rst_ready", {31'd0, o_wr_ready}, 32'd1);

    chk("end_wr_q_empty", wr_q.size(), 32'd0);
    chk("end_rd_q_empty", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
